// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bus bundle between the boot loader, the read-only program source and the
// writable i281 instruction memory.
//
// Signals
//   rom_addr    loader -> source   word index presented to the program source
//   rom_data    source -> loader   program word at rom_addr, same cycle
//   imem_we     loader -> memory   instruction-memory write enable
//   imem_waddr  loader -> memory   instruction-memory write address
//   imem_wdata  loader -> memory   instruction-memory write data
//
// Modports
//   master  the boot loader
//   slave   the program source / instruction memory side
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output rom_addr,
        input  rom_data,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Boot/reload sequencer for the i281 instruction memory. Copies DEPTH words
// from the program source into instruction memory, one word per cycle, while
// holding the CPU, then verifies an additive mod-2^DATA_W checksum and either
// releases the CPU (RUN) or keeps it held (ERR). A later load_req reloads.
//
// Parameters
//   ADDR_W     instruction-memory address width
//   DATA_W     instruction word width
//   DEPTH      words copied per load, must equal 2**ADDR_W
//   AUTO_BOOT  1: start a load on the first cycle after reset release
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          if   master side of imem_boot_loader_if (ROM read, IMEM write)
//   load_req_i   in   request a (re)load; honoured in IDLE, RUN and ERR only
//   chk_en_i     in   1: compare checksum with exp_sum_i, 0: always pass
//   exp_sum_i    in   expected mod-2^DATA_W sum of all DEPTH words
//   cpu_hold_o   out  1 while the CPU must stay stalled
//   load_done_o  out  1 when the last load passed and the CPU runs
//   load_err_o   out  1 when the last load failed its checksum
//   load_cnt_o   out  successful loads since reset, saturating at 255
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter bit AUTO_BOOT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_boot_loader_if.master bus,
    input  logic              load_req_i,
    input  logic              chk_en_i,
    input  logic [DATA_W-1:0] exp_sum_i,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [7:0]        load_cnt_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Index of the final word; reaching it in LOAD ends the copy.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        CNT_MAX   = 8'hFF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [7:0]        load_cnt_q, load_cnt_d;
    // Set by reset when AUTO_BOOT is on, consumed by the first exit from
    // IDLE, so the automatic start happens exactly once per reset.
    logic              boot_pend_q, boot_pend_d;

    // State register. An asserted rst_n aborts any load in progress; memory
    // already written is left as is because the next load rewrites every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            load_cnt_q  <= '0;
            boot_pend_q <= AUTO_BOOT;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            load_cnt_q  <= load_cnt_d;
            boot_pend_q <= boot_pend_d;
        end
    end

    // Next-state and bus outputs. The write data is a straight combinational
    // pass-through of rom_data so one word moves per cycle with no pipeline.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sum_d           = sum_q;
        load_cnt_d      = load_cnt_q;
        boot_pend_d     = boot_pend_q;
        bus.rom_addr    = '0;
        bus.imem_we     = 1'b0;
        bus.imem_waddr  = '0;
        bus.imem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (boot_pend_q || load_req_i) begin
                    state_d     = LOAD;
                    cnt_d       = '0;
                    sum_d       = '0;
                    boot_pend_d = 1'b0;
                end
            end

            LOAD: begin
                bus.rom_addr   = cnt_q;
                bus.imem_we    = 1'b1;
                bus.imem_waddr = cnt_q;
                bus.imem_wdata = bus.rom_data;
                // Carries out of the top bit are intentionally dropped.
                sum_d          = sum_q + bus.rom_data;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (!chk_en_i || (sum_q == exp_sum_i)) begin
                    state_d = RUN;
                    if (load_cnt_q != CNT_MAX) begin
                        load_cnt_d = load_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ERR;
                end
            end

            // Both resting states accept a reload; a failed load is retried
            // the same way a good one is refreshed.
            RUN, ERR: begin
                if (load_req_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_hold_o  = (state_q != RUN);
    assign load_done_o = (state_q == RUN);
    assign load_err_o  = (state_q == ERR);
    assign load_cnt_o  = load_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Self-checking bench for imem_boot_loader. Instance A boots automatically,
// instance B waits for load_req. Expected writes, checksum outcome and the
// load counter come from a small reference model working on the bench's own
// ROM array.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(4), .DATA_W(16)) ifA ();
    imem_boot_loader_if #(.ADDR_W(4), .DATA_W(16)) ifB ();

    logic [15:0] romA [16];
    logic [15:0] romB [16];

    assign ifA.rom_data = romA[ifA.rom_addr];
    assign ifB.rom_data = romB[ifB.rom_addr];

    logic        reqA, chkA, holdA, doneA, errA;
    logic [15:0] expA;
    logic [7:0]  cntA;
    logic        reqB, chkB, holdB, doneB, errB;
    logic [15:0] expB;
    logic [7:0]  cntB;

    int vectors     = 0;
    int miscompares = 0;
    int modelCntA   = 0;

    imem_boot_loader #(.ADDR_W(4), .DATA_W(16), .DEPTH(16), .AUTO_BOOT(1'b1)) dutA (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ifA),
        .load_req_i  (reqA),
        .chk_en_i    (chkA),
        .exp_sum_i   (expA),
        .cpu_hold_o  (holdA),
        .load_done_o (doneA),
        .load_err_o  (errA),
        .load_cnt_o  (cntA)
    );

    imem_boot_loader #(.ADDR_W(4), .DATA_W(16), .DEPTH(16), .AUTO_BOOT(1'b0)) dutB (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ifB),
        .load_req_i  (reqB),
        .chk_en_i    (chkB),
        .exp_sum_i   (expB),
        .cpu_hold_o  (holdB),
        .load_done_o (doneB),
        .load_err_o  (errB),
        .load_cnt_o  (cntB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic chk, input logic [15:0] exps);
        reqA = req;
        chkA = chk;
        expA = exps;
    endtask

    // Reference model: plain sum of the image modulo 2^16.
    function automatic int romSum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(romA[i]);
        return s % 65536;
    endfunction

    function automatic bit expectPass();
        return (chkA == 1'b0) || (romSum() == int'(expA));
    endfunction

    // One-cycle request from RUN/ERR; the CPU must be held in the very next cycle.
    task automatic requestLoad(input string tag);
        applyStimulus(1'b1, chkA, expA);
        @(negedge clk);
        checkOutput({tag, "_hold_rise"}, holdA, 1);
        applyStimulus(1'b0, chkA, expA);
    endtask

    // Follows one load on instance A from its first write cycle through CHECK
    // to the resting state. pulseAt raises load_req in that LOAD cycle;
    // abortAt asserts reset in that LOAD cycle and returns.
    task automatic observeLoad(input string tag, input int pulseAt, input int abortAt);
        int  w = 0;
        int  k = 0;
        bit  pass;
        while (ifA.imem_we !== 1'b1 && w < 4) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, "_start"}, ifA.imem_we, 1);
        while (ifA.imem_we === 1'b1 && k < 20) begin
            checkOutput({tag, "_waddr"}, ifA.imem_waddr, k);
            checkOutput({tag, "_raddr"}, ifA.rom_addr, k);
            checkOutput({tag, "_wdata"}, ifA.imem_wdata, romA[k % 16]);
            checkOutput({tag, "_hold"}, holdA, 1);
            if (k == abortAt) begin
                rst_n = 1'b0;
                #1;
                modelCntA = 0;
                checkOutput({tag, "_abort_we"}, ifA.imem_we, 0);
                checkOutput({tag, "_abort_hold"}, holdA, 1);
                checkOutput({tag, "_abort_raddr"}, ifA.rom_addr, 0);
                checkOutput({tag, "_abort_cnt"}, cntA, 0);
                return;
            end
            reqA = (k == pulseAt);
            @(negedge clk);
            k++;
        end
        reqA = 1'b0;
        checkOutput({tag, "_writes"}, k, 16);
        checkOutput({tag, "_chk_hold"}, holdA, 1);
        checkOutput({tag, "_chk_we"}, ifA.imem_we, 0);
        checkOutput({tag, "_chk_wdata"}, ifA.imem_wdata, 0);
        checkOutput({tag, "_chk_done"}, doneA, 0);
        pass = expectPass();
        if (pass && modelCntA < 255) modelCntA++;
        @(negedge clk);
        checkOutput({tag, "_done"}, doneA, pass);
        checkOutput({tag, "_err"}, errA, !pass);
        checkOutput({tag, "_hold_end"}, holdA, !pass);
        checkOutput({tag, "_cnt"}, cntA, modelCntA);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        int w;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h1078);
        reqB = 1'b0;
        chkB = 1'b1;
        expB = 16'h1078;
        for (int i = 0; i < 16; i++) begin
            romA[i] = 16'h0100 + 16'(i);
            romB[i] = 16'h0100 + 16'(i);
        end
        repeat (2) @(negedge clk);

        // Reset values
        checkOutput("rst_hold", holdA, 1);
        checkOutput("rst_we", ifA.imem_we, 0);
        checkOutput("rst_waddr", ifA.imem_waddr, 0);
        checkOutput("rst_wdata", ifA.imem_wdata, 0);
        checkOutput("rst_raddr", ifA.rom_addr, 0);
        checkOutput("rst_done", doneA, 0);
        checkOutput("rst_err", errA, 0);
        checkOutput("rst_cnt", cntA, 0);
        checkOutput("rst_holdB", holdB, 1);

        // Automatic boot of the 0100..010F image
        rst_n = 1'b1;
        observeLoad("t1_boot", -1, -1);
        checkOutput("t1_B_idle_hold", holdB, 1);
        checkOutput("t1_B_idle_we", ifB.imem_we, 0);

        // Bad checksum, stay held, then retry with the right one
        applyStimulus(1'b0, 1'b1, 16'h1079);
        requestLoad("t2_bad");
        observeLoad("t2_bad", -1, -1);
        repeat (3) @(negedge clk);
        checkOutput("t2_err_stays", errA, 1);
        checkOutput("t2_hold_stays", holdA, 1);
        applyStimulus(1'b0, 1'b1, 16'h1078);
        requestLoad("t2_retry");
        observeLoad("t2_retry", -1, -1);

        // Checksum wrap, then checking disabled
        for (int i = 0; i < 16; i++) romA[i] = 16'hFFFF;
        applyStimulus(1'b0, 1'b1, 16'hFFF0);
        requestLoad("t3_wrap");
        observeLoad("t3_wrap", -1, -1);
        applyStimulus(1'b0, 1'b0, 16'h1234);
        requestLoad("t3_nochk");
        observeLoad("t3_nochk", -1, -1);

        // Reset in LOAD cycle 7, then a complete reboot
        for (int i = 0; i < 16; i++) romA[i] = 16'h0100 + 16'(i);
        applyStimulus(1'b0, 1'b1, 16'h1078);
        requestLoad("t4_abort");
        observeLoad("t4_abort", -1, 7);
        @(negedge clk);
        rst_n = 1'b1;
        observeLoad("t4_reboot", -1, -1);

        // Reload from RUN with a request pulse in LOAD cycle 3 that is ignored
        requestLoad("t5_reload");
        observeLoad("t5_reload", 3, -1);
        checkOutput("t5_no_requeue", ifA.imem_we, 0);

        // Randomized images and checksum settings
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) romA[i] = 16'($urandom);
            s = romSum();
            if ($urandom_range(0, 1) == 1)
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 16'(s));
            else
                applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                              16'((s + int'($urandom_range(1, 65535))) % 65536));
            requestLoad("rnd");
            observeLoad("rnd", -1, -1);
        end

        // Instance B never auto-booted; now drive it to counter saturation
        checkOutput("t6_B_idle_hold", holdB, 1);
        checkOutput("t6_B_idle_done", doneB, 0);
        checkOutput("t6_B_idle_cnt", cntB, 0);
        for (int n = 1; n <= 260; n++) begin
            reqB = 1'b1;
            @(negedge clk);
            reqB = 1'b0;
            checkOutput("t6_B_hold_rise", holdB, 1);
            w = 0;
            while (doneB !== 1'b1 && w < 30) begin
                @(negedge clk);
                w++;
            end
            checkOutput("t6_B_done", doneB, 1);
            checkOutput("t6_B_cnt", cntB, (n > 255) ? 255 : n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
